// File: rtl/core_pipe_pkg.sv
// Types and constants shared by the RV32I pipeline stages.
package core_pipe_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {BOOT, RUN} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       count_q <= '0;
    else if (inc && (count_q != '1))  count_q <= count_q + 1'b1;
  end

  assign count = count_q;
endmodule

// File: rtl/if_fetch_stage.sv
// PC generation and IF/ID register: boot delay, stall hold, redirect squash,
// plus saturating stall/flush counters.
module if_fetch_stage
  import core_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST    = core_pipe_pkg::NOP_INST,
  parameter int              BOOT_CYCLES = 2,
  parameter int              CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic [XLEN-1:0]   imem_addr_o,
  input  logic [XLEN-1:0]   imem_rdata_i,
  output logic [XLEN-1:0]   if_id_pc_o,
  output logic [XLEN-1:0]   if_id_inst_o,
  output logic              if_id_valid_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  localparam int          BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam if_id_t      BUBBLE    = '{pc: '0, inst: NOP_INST, valid: 1'b0};

  fetch_state_t    state_q;
  logic [BW-1:0]   boot_cnt_q;
  logic [XLEN-1:0] pc_q;
  if_id_t          if_id_q;
  logic            misalign_q;
  logic            stall_inc, flush_inc;

  // Redirects are honoured in both states so an early branch is not lost;
  // imem_rdata_i is only consumed on the RUN advance path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_PC;
      if_id_q    <= BUBBLE;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (redirect_valid_i) begin
        pc_q       <= {redirect_pc_i[XLEN-1:2], 2'b00};
        misalign_q <= |redirect_pc_i[1:0];
      end
      case (state_q)
        BOOT: begin
          boot_cnt_q <= boot_cnt_q + 1'b1;
          if (boot_cnt_q == BOOT_LAST) state_q <= RUN;
        end
        RUN: begin
          if (redirect_valid_i) begin
            if_id_q <= BUBBLE;
          end else if (!stall_i) begin
            if_id_q <= '{pc: pc_q, inst: imem_rdata_i, valid: 1'b1};
            pc_q    <= pc_q + 32'd4;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign stall_inc = (state_q == RUN) && stall_i && !redirect_valid_i;
  assign flush_inc = redirect_valid_i;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_cnt_o)
  );

  assign imem_addr_o   = pc_q;
  assign if_id_pc_o    = if_id_q.pc;
  assign if_id_inst_o  = if_id_q.inst;
  assign if_id_valid_o = if_id_q.valid;
  assign misalign_o    = misalign_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed + randomized bench for if_fetch_stage against a cycle-level model.
module tb_if_fetch_stage;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int BOOT_N  = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              stall_i = 1'b0;
  logic              redirect_valid_i = 1'b0;
  logic [31:0]       redirect_pc_i = '0;
  logic [31:0]       imem_addr_o;
  logic [31:0]       imem_rdata_i;
  logic [31:0]       if_id_pc_o;
  logic [31:0]       if_id_inst_o;
  logic              if_id_valid_o;
  logic              misalign_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  int vectors = 0;
  int errors  = 0;

  if_fetch_stage #(
    .RESET_PC   (32'h0),
    .NOP_INST   (NOP),
    .BOOT_CYCLES(BOOT_N),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .if_id_pc_o       (if_id_pc_o),
    .if_id_inst_o     (if_id_inst_o),
    .if_id_valid_o    (if_id_valid_o),
    .misalign_o       (misalign_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_rdata_i = mem_word(imem_addr_o);

  // Reference model state
  logic [31:0] m_pc, m_ipc, m_inst;
  logic        m_v, m_mis;
  int          m_stall, m_flush, m_boot_left;

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_inst = NOP; m_v = 1'b0; m_mis = 1'b0;
    m_stall = 0; m_flush = 0; m_boot_left = BOOT_N;
  endtask

  task automatic m_edge(input bit st, input bit rd, input logic [31:0] tgt);
    m_mis = 1'b0;
    if (rd) begin
      m_flush = sat_inc(m_flush);
      m_mis   = (tgt[1:0] != 2'b00);
    end
    if (m_boot_left > 0) begin
      if (rd) m_pc = tgt & 32'hFFFF_FFFC;
      m_boot_left--;
    end else if (rd) begin
      m_pc = tgt & 32'hFFFF_FFFC;
      m_ipc = 32'h0; m_inst = NOP; m_v = 1'b0;
    end else if (st) begin
      m_stall = sat_inc(m_stall);
    end else begin
      m_ipc = m_pc; m_inst = mem_word(m_pc); m_v = 1'b1;
      m_pc  = m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".imem_addr"}, imem_addr_o,        m_pc);
    chk({ph, ".ifid_pc"},   if_id_pc_o,         m_ipc);
    chk({ph, ".ifid_inst"}, if_id_inst_o,       m_inst);
    chk({ph, ".ifid_vld"},  32'(if_id_valid_o), 32'(m_v));
    chk({ph, ".misalign"},  32'(misalign_o),    32'(m_mis));
    chk({ph, ".stall_cnt"}, 32'(stall_cnt_o),   32'(m_stall));
    chk({ph, ".flush_cnt"}, 32'(flush_cnt_o),   32'(m_flush));
  endtask

  // Called at a negedge: drive, take the edge, compare mid-cycle.
  task automatic step(input bit st, input bit rd, input logic [31:0] tgt, input string ph);
    stall_i = st; redirect_valid_i = rd; redirect_pc_i = tgt;
    @(posedge clk);
    m_edge(st, rd, tgt);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic apply_reset(input string ph);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all(ph);
    @(negedge clk);
    stall_i = 1'b0; redirect_valid_i = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    apply_reset("reset");

    repeat (2) step(0, 0, 32'h0, "boot");
    repeat (3) step(0, 0, 32'h0, "fetch");
    repeat (3) step(1, 0, 32'h0, "stall");
    step(0, 0, 32'h0, "release");
    step(0, 1, 32'h100, "redir");
    repeat (2) step(0, 0, 32'h0, "tgt");
    step(1, 1, 32'h200, "redir_stall");
    step(0, 0, 32'h0, "post_rs");
    step(0, 1, 32'h203, "misal");
    step(0, 0, 32'h0, "misal_clr");
    step(0, 1, 32'hFFFF_FFFC, "wrap_redir");
    repeat (2) step(0, 0, 32'h0, "wrap");
    repeat (20) step(1, 0, 32'h0, "sat");

    // Reset asserted mid-stall, between clock edges
    stall_i = 1'b1; redirect_valid_i = 1'b0;
    @(posedge clk);
    m_edge(1, 0, 32'h0);
    #2;
    apply_reset("midreset");
    step(0, 1, 32'h40, "boot_redir");
    step(1, 0, 32'h0, "boot_stall");
    repeat (2) step(0, 0, 32'h0, "boot_fetch");

    for (int i = 0; i < 400; i++) begin
      bit st, rd;
      logic [31:0] tgt;
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 12);
      tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom_range(0, 4095));
      if (i == 200) begin
        @(posedge clk);
        m_edge(st, rd, tgt);
        #3;
        apply_reset("rand_reset");
      end else begin
        step(st, rd, tgt, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
